// File: rtl/bus_pkg.sv
// Shared bus definitions: source index map and the bus word type.
package bus_pkg;
  localparam int NUM_BUS_SRC = 26;
  localparam int BUS_W       = 32;

  localparam int SRC_RA     = 0;
  localparam int SRC_R0     = 1;   // R0..R15 occupy 1..16
  localparam int SRC_R15    = 16;
  localparam int SRC_HI     = 17;
  localparam int SRC_LO     = 18;
  localparam int SRC_ZHI    = 19;
  localparam int SRC_ZLO    = 20;
  localparam int SRC_PC     = 21;
  localparam int SRC_MDR    = 22;
  localparam int SRC_MAR    = 23;
  localparam int SRC_C      = 24;
  localparam int SRC_INPORT = 25;

  typedef logic [BUS_W-1:0] bus_word_t;
endpackage

// File: rtl/prio_enc_hi.sv
// Highest-set-bit priority encoder with any/multi flags.
module prio_enc_hi #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_vec,
  output logic [IW-1:0] o_idx,
  output logic          o_any,
  output logic          o_multi
);
  always_comb begin
    o_idx = '0;
    for (int i = 0; i < N; i++)
      if (i_vec[i]) o_idx = IW'(i);
  end

  assign o_any = |i_vec;
  // Clearing the lowest set bit leaves something only when two or more are set.
  assign o_multi = |(i_vec & (i_vec - N'(1)));
endmodule

// File: rtl/bus_mux_reg.sv
// Registered shared-bus multiplexer: last-wins priority, idle policy,
// contention pulse plus sticky flag and saturating event counter.
module bus_mux_reg
  import bus_pkg::*;
#(
  parameter int WIDTH        = BUS_W,
  parameter int NUM_SRC      = NUM_BUS_SRC,
  parameter int HOLD_ON_IDLE = 1,
  parameter int CNT_W        = 8,
  parameter int SEL_W        = $clog2(NUM_SRC)
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic [NUM_SRC-1:0]       src_out_en,
  input  logic                     err_clr,
  output logic [WIDTH-1:0]         bus_out,
  output logic                     bus_valid,
  output logic [SEL_W-1:0]         sel_idx,
  output logic                     contention,
  output logic                     contention_sticky,
  output logic [CNT_W-1:0]         contention_count
);
  logic [SEL_W-1:0] w_idx;
  logic             w_any;
  logic             w_multi;
  logic [WIDTH-1:0] w_word;

  prio_enc_hi #(.N(NUM_SRC), .IW(SEL_W)) u_prio (
    .i_vec   (src_out_en),
    .o_idx   (w_idx),
    .o_any   (w_any),
    .o_multi (w_multi)
  );

  assign w_word = src_data[w_idx*WIDTH +: WIDTH];

  logic [WIDTH-1:0] r_bus;
  logic             r_valid;
  logic [SEL_W-1:0] r_sel;
  logic             r_cont;
  logic             r_sticky;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_bus    <= '0;
      r_valid  <= 1'b0;
      r_sel    <= '0;
      r_cont   <= 1'b0;
      r_sticky <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_cont  <= w_multi;
      r_valid <= w_any;
      if (w_any) begin
        r_bus <= w_word;
        r_sel <= w_idx;
      end else if (HOLD_ON_IDLE == 0) begin
        r_bus <= '0;
      end
      // A contention event outranks a same-cycle err_clr: it restarts the count at 1.
      if (w_multi) begin
        r_sticky <= 1'b1;
        if (err_clr)          r_cnt <= CNT_W'(1);
        else if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
      end else if (err_clr) begin
        r_sticky <= 1'b0;
        r_cnt    <= '0;
      end
    end
  end

  assign bus_out           = r_bus;
  assign bus_valid         = r_valid;
  assign sel_idx           = r_sel;
  assign contention        = r_cont;
  assign contention_sticky = r_sticky;
  assign contention_count  = r_cnt;
endmodule

// File: tb/tb_bus_mux_reg.sv
// Bench for bus_mux_reg: default-size instance plus a 4x8 zero-on-idle instance,
// each checked every cycle against a behavioural model and by literal spot checks.
module tb_bus_mux_reg;
  logic clock = 1'b0;
  logic clear = 1'b0;
  always #5 clock = ~clock;

  // default instance (26 x 32, hold on idle)
  logic [31:0]     src_w [26];
  logic [26*32-1:0] src_data;
  logic [25:0]     en;
  logic            err_clr;
  logic [31:0]     bus_out;
  logic            bus_valid;
  logic [4:0]      sel_idx;
  logic            cont, sticky;
  logic [7:0]      cnt;

  // small instance (4 x 8, zero on idle)
  logic [7:0]  s_w [4];
  logic [31:0] s_data;
  logic [3:0]  s_en;
  logic        s_err;
  logic [7:0]  s_bus;
  logic        s_valid;
  logic [1:0]  s_sel;
  logic        s_cont, s_sticky;
  logic [7:0]  s_cnt;

  for (genvar g = 0; g < 26; g++) begin : g_pack
    assign src_data[g*32 +: 32] = src_w[g];
  end
  for (genvar g = 0; g < 4; g++) begin : g_spack
    assign s_data[g*8 +: 8] = s_w[g];
  end

  bus_mux_reg u_main (
    .clock(clock), .clear(clear), .src_data(src_data), .src_out_en(en), .err_clr(err_clr),
    .bus_out(bus_out), .bus_valid(bus_valid), .sel_idx(sel_idx), .contention(cont),
    .contention_sticky(sticky), .contention_count(cnt)
  );

  bus_mux_reg #(.WIDTH(8), .NUM_SRC(4), .HOLD_ON_IDLE(0), .CNT_W(8)) u_small (
    .clock(clock), .clear(clear), .src_data(s_data), .src_out_en(s_en), .err_clr(s_err),
    .bus_out(s_bus), .bus_valid(s_valid), .sel_idx(s_sel), .contention(s_cont),
    .contention_sticky(s_sticky), .contention_count(s_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int hi_bit(input logic [31:0] v);
    int r = 0;
    for (int i = 0; i < 32; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Behavioural model: winner = highest enable, event = two or more enables.
  logic [31:0] m_bus = '0;  logic m_valid = 0;  int m_sel = 0;
  logic m_cont = 0;  logic m_sticky = 0;  int m_cnt = 0;
  logic [7:0]  n_bus = '0;  logic n_valid = 0;  int n_sel = 0;
  logic n_cont = 0;  logic n_sticky = 0;  int n_cnt = 0;

  always @(posedge clock or negedge clear) begin
    if (!clear) begin
      m_bus <= '0; m_valid <= 0; m_sel <= 0; m_cont <= 0; m_sticky <= 0; m_cnt <= 0;
    end else begin
      m_valid <= (en != 0);
      m_cont  <= ($countones(en) > 1);
      if (en != 0) begin
        m_bus <= src_w[hi_bit(32'(en))];
        m_sel <= hi_bit(32'(en));
      end
      if ($countones(en) > 1) begin
        m_sticky <= 1;
        m_cnt    <= err_clr ? 1 : ((m_cnt + 1 > 255) ? 255 : m_cnt + 1);
      end else if (err_clr) begin
        m_sticky <= 0;
        m_cnt    <= 0;
      end
    end
  end

  always @(posedge clock or negedge clear) begin
    if (!clear) begin
      n_bus <= '0; n_valid <= 0; n_sel <= 0; n_cont <= 0; n_sticky <= 0; n_cnt <= 0;
    end else begin
      n_valid <= (s_en != 0);
      n_cont  <= ($countones(s_en) > 1);
      n_bus   <= (s_en != 0) ? s_w[hi_bit(32'(s_en))] : 8'h00;
      if (s_en != 0) n_sel <= hi_bit(32'(s_en));
      if ($countones(s_en) > 1) begin
        n_sticky <= 1;
        n_cnt    <= s_err ? 1 : ((n_cnt + 1 > 255) ? 255 : n_cnt + 1);
      end else if (s_err) begin
        n_sticky <= 0;
        n_cnt    <= 0;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en && clear) begin
      check("m.bus_out",    bus_out,     m_bus);
      check("m.bus_valid",  32'(bus_valid), 32'(m_valid));
      check("m.sel_idx",    32'(sel_idx), m_sel);
      check("m.contention", 32'(cont),   32'(m_cont));
      check("m.sticky",     32'(sticky), 32'(m_sticky));
      check("m.count",      32'(cnt),    m_cnt);
      check("s.bus_out",    32'(s_bus),  32'(n_bus));
      check("s.bus_valid",  32'(s_valid), 32'(n_valid));
      check("s.sel_idx",    32'(s_sel),  n_sel);
      check("s.contention", 32'(s_cont), 32'(n_cont));
      check("s.sticky",     32'(s_sticky), 32'(n_sticky));
      check("s.count",      32'(s_cnt),  n_cnt);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  int  hi_tab [16]    = '{0,0,1,1,2,2,2,2,3,3,3,3,3,3,3,3};
  bit  multi_tab [16] = '{0,0,0,1,0,1,1,1,0,1,1,1,1,1,1,1};

  initial begin
    for (int i = 0; i < 26; i++) src_w[i] = '0;
    for (int i = 0; i < 4; i++) s_w[i] = 8'h10 + 8'(i);
    en = '0; err_clr = 0; s_en = '0; s_err = 0;
    tick(); tick();
    check("reset bus_out", bus_out, 32'h0);
    check("reset valid",   32'(bus_valid), 32'h0);
    check("reset count",   32'(cnt), 32'h0);
    clear = 1'b1;
    chk_en = 1'b1;

    // single source: PC
    src_w[bus_pkg::SRC_PC] = 32'h0000_0123;
    en = '0; en[bus_pkg::SRC_PC] = 1'b1;
    s_en = 4'b0100;
    tick();
    check("pc bus_out", bus_out, 32'h0000_0123);
    check("pc valid",   32'(bus_valid), 32'h1);
    check("pc sel",     32'(sel_idx), 32'd21);
    check("pc cont",    32'(cont), 32'h0);
    check("s single bus", 32'(s_bus), 32'h12);

    // contention R3 + MDR
    src_w[4] = 32'h11; src_w[bus_pkg::SRC_MDR] = 32'h22;
    en = '0; en[4] = 1'b1; en[bus_pkg::SRC_MDR] = 1'b1;
    s_en = '0;
    tick();
    check("cont bus_out", bus_out, 32'h22);
    check("cont sel",     32'(sel_idx), 32'd22);
    check("cont pulse",   32'(cont), 32'h1);
    check("cont sticky",  32'(sticky), 32'h1);
    check("cont count",   32'(cnt), 32'h1);
    en = '0;
    tick();
    check("cont pulse drop", 32'(cont), 32'h0);
    check("cont sticky hold", 32'(sticky), 32'h1);

    // idle policy
    src_w[0] = 32'hA5A5_A5A5; en = 26'h1;
    s_w[1] = 8'hA5; s_en = 4'b0010;
    tick();
    check("idle load", bus_out, 32'hA5A5_A5A5);
    check("s idle load", 32'(s_bus), 32'hA5);
    en = '0; s_en = '0;
    tick();
    check("idle hold bus", bus_out, 32'hA5A5_A5A5);
    check("idle valid",    32'(bus_valid), 32'h0);
    check("s idle zero",   32'(s_bus), 32'h0);
    check("s idle sel hold", 32'(s_sel), 32'h1);

    // err_clr race
    err_clr = 1; tick();
    check("clr count", 32'(cnt), 32'h0);
    err_clr = 0; en = 26'h3;
    repeat (5) tick();
    check("five events", 32'(cnt), 32'd5);
    err_clr = 1;
    tick();
    check("race sticky", 32'(sticky), 32'h1);
    check("race count",  32'(cnt), 32'h1);
    en = '0;
    tick();
    check("clr2 sticky", 32'(sticky), 32'h0);
    check("clr2 count",  32'(cnt), 32'h0);
    err_clr = 0;

    // saturation
    en = 26'h3;
    repeat (300) tick();
    check("sat count", 32'(cnt), 32'd255);
    check("sat pulse", 32'(cont), 32'h1);
    en = '0;

    // mid-operation reset
    src_w[10] = 32'hDEAD_BEEF; en = '0; en[10] = 1'b1;
    tick();
    check("pre-reset bus", bus_out, 32'hDEAD_BEEF);
    #2 clear = 1'b0;
    #1;
    check("async bus_out", bus_out, 32'h0);
    check("async valid",   32'(bus_valid), 32'h0);
    check("async sticky",  32'(sticky), 32'h0);
    check("async count",   32'(cnt), 32'h0);
    tick();
    check("held reset", bus_out, 32'h0);
    clear = 1'b1;
    tick();
    check("fresh bus",    bus_out, 32'hDEAD_BEEF);
    check("fresh sel",    32'(sel_idx), 32'd10);
    check("fresh sticky", 32'(sticky), 32'h0);
    en = '0;

    // small instance enable sweep
    for (int i = 0; i < 4; i++) s_w[i] = 8'h10 + 8'(i);
    for (int p = 0; p < 16; p++) begin
      s_en = 4'(p);
      tick();
      if (p != 0) check("sweep sel", 32'(s_sel), hi_tab[p]);
      check("sweep cont",  32'(s_cont), 32'(multi_tab[p]));
      check("sweep valid", 32'(s_valid), (p != 0) ? 32'h1 : 32'h0);
    end
    s_en = '0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
